fb_cmd_scheduler: RTL and testbench

FB_CMD_SCHEDULER -- requirements
Module: fb_cmd_scheduler

---
 rtl/fb_cmd_scheduler.sv | 109 ++++++++++
 tb/tb_fb_cmd_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_cmd_scheduler.sv
// fb_cmd_scheduler: latches framebuffer clear/commit commands and sequences the colour/depth apply handshakes.
// Ports: clk/resetn (async active-low); cmdValid/cmdReady command handshake with cmdColorCommit,
// cmdColorMemset, cmdDepthMemset, cmdClearColor, cmdClearDepth; colour framebuffer side colorApply/colorApplied,
// colorCmdCommit, colorCmdMemset, colorClearColor; depth framebuffer side depthApply/depthApplied,
// depthCmdMemset, depthClearDepth; fragStall holds the pixel pipeline; commitCount counts finished commits.
// Define FB_CMD_SCHEDULER_PARALLEL_DEPTH_EN to run the depth memset alongside the colour request.
module fb_cmd_scheduler #(
  parameter int PIXEL_WIDTH = 16,
  parameter int DEPTH_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cmdValid,
  output logic                   cmdReady,
  input  logic                   cmdColorCommit,
  input  logic                   cmdColorMemset,
  input  logic                   cmdDepthMemset,
  input  logic [PIXEL_WIDTH-1:0] cmdClearColor,
  input  logic [DEPTH_WIDTH-1:0] cmdClearDepth,
  output logic                   colorApply,
  input  logic                   colorApplied,
  output logic                   colorCmdCommit,
  output logic                   colorCmdMemset,
  output logic [PIXEL_WIDTH-1:0] colorClearColor,
  output logic                   depthApply,
  input  logic                   depthApplied,
  output logic                   depthCmdMemset,
  output logic [DEPTH_WIDTH-1:0] depthClearDepth,
  output logic                   fragStall,
  output logic [COUNT_WIDTH-1:0] commitCount
);
  typedef enum logic [2:0] {IDLE, COLOR_REQ, COLOR_RUN, DEPTH_REQ, DEPTH_RUN} state_t;
  state_t state_q, state_d, color_exit;
  logic commit_q, commit_d, cmemset_q, cmemset_d, dmemset_q, dmemset_d;
  logic [PIXEL_WIDTH-1:0] color_q, color_d;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic accept, color_done;
  assign accept = cmdValid & (state_q == IDLE);
`ifdef FB_CMD_SCHEDULER_PARALLEL_DEPTH_EN
  // Depth apply rides alongside the colour request; it drops on its own applied==0 and the
  // colour run phase waits for both framebuffers to be idle again.
  logic dpar_q, dpar_d;
  assign color_done = colorApplied & depthApplied & ~dpar_q;
  assign color_exit = IDLE;
  always_comb dpar_d = accept ? (cmdColorCommit | cmdColorMemset) & cmdDepthMemset : dpar_q & depthApplied;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) dpar_q <= 1'b0;
    else dpar_q <= dpar_d;
`else
  assign color_done = colorApplied;
  assign color_exit = dmemset_q ? DEPTH_REQ : IDLE;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      commit_q  <= 1'b0;
      cmemset_q <= 1'b0;
      dmemset_q <= 1'b0;
      color_q   <= '0;
      depth_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      commit_q  <= commit_d;
      cmemset_q <= cmemset_d;
      dmemset_q <= dmemset_d;
      color_q   <= color_d;
      depth_q   <= depth_d;
      count_q   <= count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = (cmdColorCommit | cmdColorMemset) ? COLOR_REQ : cmdDepthMemset ? DEPTH_REQ : IDLE;
      COLOR_REQ: if (!colorApplied) state_d = COLOR_RUN;
      COLOR_RUN: if (color_done) state_d = color_exit;
      DEPTH_REQ: if (!depthApplied) state_d = DEPTH_RUN;
      DEPTH_RUN: if (depthApplied) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    commit_d  = accept ? cmdColorCommit : commit_q;
    cmemset_d = accept ? cmdColorMemset : cmemset_q;
    dmemset_d = accept ? cmdDepthMemset : dmemset_q;
    color_d   = accept ? cmdClearColor : color_q;
    depth_d   = accept ? cmdClearDepth : depth_q;
    count_d   = (state_q == COLOR_RUN && color_done && commit_q) ? count_q + 1'b1 : count_q;
  end
  always_comb begin
    cmdReady   = state_q == IDLE;
    fragStall  = state_q != IDLE;
    colorApply = state_q == COLOR_REQ;
`ifdef FB_CMD_SCHEDULER_PARALLEL_DEPTH_EN
    depthApply = (state_q == DEPTH_REQ) | dpar_q;
`else
    depthApply = state_q == DEPTH_REQ;
`endif
  end
  assign colorCmdCommit  = commit_q;
  assign colorCmdMemset  = cmemset_q;
  assign colorClearColor = color_q;
  assign depthCmdMemset  = dmemset_q;
  assign depthClearDepth = depth_q;
  assign commitCount     = count_q;
endmodule

// File: tb/tb_fb_cmd_scheduler.sv
// tb_fb_cmd_scheduler: directed table, randomized commands against a timing model, reset and wrap sequences.
module tb_fb_cmd_scheduler;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic resetn, cmdValid, cmdReady, cmdColorCommit, cmdColorMemset, cmdDepthMemset;
  logic [15:0] cmdClearColor, cmdClearDepth, colorClearColor, depthClearDepth;
  logic colorApply, colorApplied, colorCmdCommit, colorCmdMemset;
  logic depthApply, depthApplied, depthCmdMemset, fragStall;
  logic [CW-1:0] commitCount;
  fb_cmd_scheduler #(.PIXEL_WIDTH(16), .DEPTH_WIDTH(16), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdColorCommit(cmdColorCommit), .cmdColorMemset(cmdColorMemset), .cmdDepthMemset(cmdDepthMemset),
    .cmdClearColor(cmdClearColor), .cmdClearDepth(cmdClearDepth),
    .colorApply(colorApply), .colorApplied(colorApplied), .colorCmdCommit(colorCmdCommit),
    .colorCmdMemset(colorCmdMemset), .colorClearColor(colorClearColor),
    .depthApply(depthApply), .depthApplied(depthApplied), .depthCmdMemset(depthCmdMemset),
    .depthClearDepth(depthClearDepth), .fragStall(fragStall), .commitCount(commitCount)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int passed = 0, total = 0;
  int c_drop = 0, c_rise = 1, d_drop = 0, d_rise = 1, c_rise_at = 0;
  logic [CW-1:0] m_cnt;
  typedef struct {
    logic commit, cm, dm;
    logic [15:0] col, dep;
    int dc, rc, dd, rd;
    int busy, ca, da, cnt;
  } vec_t;
  typedef struct {
    int busy, ca, da, cr, dr, cfirst, dfirst;
    logic to;
  } res_t;
  vec_t tbl[7];
  // Framebuffer models: applied drops c_drop cycles after apply is first seen, returns c_rise cycles later.
  initial begin
    colorApplied = 1'b1;
    forever begin
      @(negedge clk);
      if (colorApply === 1'b1) begin
        repeat (c_drop) @(negedge clk);
        colorApplied = 1'b0;
        repeat (c_rise) @(negedge clk);
        colorApplied = 1'b1;
        c_rise_at = cyc;
      end
    end
  end
  initial begin
    depthApplied = 1'b1;
    forever begin
      @(negedge clk);
      if (depthApply === 1'b1) begin
        repeat (d_drop) @(negedge clk);
        depthApplied = 1'b0;
        repeat (d_rise) @(negedge clk);
        depthApplied = 1'b1;
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else passed++;
  endtask
  // Reference timing: each buffer phase takes drop+1 request cycles plus rise run cycles.
  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    int tc = v.dc + 1 + v.rc, td = v.dd + 1 + v.rd;
    logic color = v.commit | v.cm;
`ifdef FB_CMD_SCHEDULER_PARALLEL_DEPTH_EN
    o.busy = color ? (v.dm ? (tc > td ? tc : td) : tc) : (v.dm ? td : 0);
`else
    o.busy = (color ? tc : 0) + (v.dm ? td : 0);
`endif
    o.ca = color ? v.dc + 1 : 0;
    o.da = v.dm ? v.dd + 1 : 0;
    return o;
  endfunction
  task automatic run_cmd(input vec_t v, output res_t r);
    logic pc = 1'b0, pd = 1'b0;
    r = '{default: 0};
    @(negedge clk);
    chk("ready_before_accept", cmdReady, 1);
    {cmdColorCommit, cmdColorMemset, cmdDepthMemset} = {v.commit, v.cm, v.dm};
    cmdClearColor = v.col;
    cmdClearDepth = v.dep;
    c_drop = v.dc; c_rise = v.rc; d_drop = v.dd; d_rise = v.rd;
    cmdValid = 1'b1;
    @(posedge clk);
    r.to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cmdValid = 1'b0;
      {cmdColorCommit, cmdColorMemset, cmdDepthMemset} = 3'($urandom);
      cmdClearColor = 16'($urandom);
      cmdClearDepth = 16'($urandom);
      if (!fragStall) begin
        r.to = 1'b0;
        break;
      end
      r.busy++;
      if (colorApply) begin
        r.ca++;
        if (!pc) begin r.cr++; if (r.cr == 1) r.cfirst = cyc; end
      end
      if (depthApply) begin
        r.da++;
        if (!pd) begin r.dr++; if (r.dr == 1) r.dfirst = cyc; end
      end
      pc = colorApply;
      pd = depthApply;
    end
    chk("cmd_timeout", r.to, 0);
  endtask
  task automatic check_cmd(input vec_t v, input res_t r, input string t);
    chk({t, "_busy"}, r.busy, v.busy);
    chk({t, "_color_apply_cycles"}, r.ca, v.ca);
    chk({t, "_depth_apply_cycles"}, r.da, v.da);
    chk({t, "_color_apply_rises"}, r.cr, v.ca > 0 ? 1 : 0);
    chk({t, "_depth_apply_rises"}, r.dr, v.da > 0 ? 1 : 0);
    chk({t, "_count"}, commitCount, v.cnt);
    chk({t, "_flags"}, {colorCmdCommit, colorCmdMemset, depthCmdMemset}, {v.commit, v.cm, v.dm});
    chk({t, "_clear_color"}, colorClearColor, v.col);
    chk({t, "_clear_depth"}, depthClearDepth, v.dep);
    if (v.ca > 0 && v.da > 0) begin
`ifdef FB_CMD_SCHEDULER_PARALLEL_DEPTH_EN
      chk({t, "_applies_same_cycle"}, r.dfirst, r.cfirst);
`else
      chk({t, "_depth_after_color_done"}, r.dfirst > c_rise_at, 1);
`endif
    end
  endtask
  task automatic wait_idle_fb();
    int n = 0;
    while (!(colorApplied && depthApplied) && n < 100) begin @(negedge clk); n++; end
    chk("fb_idle_wait", n < 100, 1);
  endtask
  task automatic mid_reset(input int dc, input int rc, input int wait_n, input logic in_req, input string t);
    int bad = 0;
    @(negedge clk);
    {cmdColorCommit, cmdColorMemset, cmdDepthMemset} = 3'b101;
    cmdClearColor = 16'h1234;
    cmdClearDepth = 16'h5678;
    c_drop = dc; c_rise = rc; d_drop = 0; d_rise = 1;
    cmdValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    repeat (wait_n) @(negedge clk);
    chk({t, "_pre_apply"}, colorApply, in_req);
    chk({t, "_pre_stall"}, fragStall, 1);
    #2 resetn = 1'b0;
    #1;
    chk({t, "_color_apply"}, colorApply, 0);
    chk({t, "_depth_apply"}, depthApply, 0);
    chk({t, "_ready"}, cmdReady, 1);
    chk({t, "_stall"}, fragStall, 0);
    chk({t, "_count"}, commitCount, 0);
    chk({t, "_clear_color"}, colorClearColor, 0);
    m_cnt = '0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (fragStall || colorApply || depthApply) bad++;
    end
    chk({t, "_not_resumed"}, bad, 0);
    wait_idle_fb();
  endtask
  initial begin
    vec_t v;
    res_t r;
    cmdValid = 1'b0;
    {cmdColorCommit, cmdColorMemset, cmdDepthMemset} = 3'b000;
    cmdClearColor = '0;
    cmdClearDepth = '0;
    m_cnt = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("rst_ready", cmdReady, 1);
    chk("rst_stall", fragStall, 0);
    chk("rst_applies", {colorApply, depthApply}, 0);
    chk("rst_count", commitCount, 0);
    chk("rst_latched", {colorCmdCommit, colorCmdMemset, depthCmdMemset, colorClearColor, depthClearDepth}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'hA5A5, 16'h0000, 0, 10, 0, 1, 11, 1, 0, 1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'hF0F0, 16'hFFFF, 0, 3, 0, 2, 7, 1, 1, 1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h0001, 16'h8000, 0, 1, 2, 1, 4, 0, 3, 1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h7E57, 16'hC0DE, 1, 1, 0, 1, 5, 2, 1, 2};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h1111, 0, 1, 0, 1, 2, 1, 0, 3};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h00FF, 16'h2222, 0, 2, 0, 1, 3, 1, 0, 3};
`ifdef FB_CMD_SCHEDULER_PARALLEL_DEPTH_EN
    tbl[1].busy = 4;
    tbl[4].busy = 3;
`endif
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].commit) m_cnt = m_cnt + 1'b1;
      run_cmd(tbl[i], r);
      check_cmd(tbl[i], r, $sformatf("vec%0d", i));
    end
    for (int i = 0; i < 40; i++) begin
      v.commit = 1'($urandom); v.cm = 1'($urandom); v.dm = 1'($urandom);
      v.col = 16'($urandom); v.dep = 16'($urandom);
      v.dc = $urandom_range(0, 3); v.rc = $urandom_range(1, 4);
      v.dd = $urandom_range(0, 3); v.rd = $urandom_range(1, 4);
      v = model(v);
      if (v.commit) m_cnt = m_cnt + 1'b1;
      v.cnt = int'(m_cnt);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(v, r);
      check_cmd(v, r, $sformatf("rnd%0d", i));
    end
    mid_reset(0, 20, 2, 1'b0, "rst_in_run");
    mid_reset(5, 2, 1, 1'b1, "rst_in_req");
    v = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1, 0, 1, 2, 1, 0, 0};
    while (m_cnt != 8'hFF) begin
      m_cnt = m_cnt + 1'b1;
      run_cmd(v, r);
    end
    chk("wrap_pre_max", commitCount, 8'hFF);
    m_cnt = m_cnt + 1'b1;
    v.cnt = int'(m_cnt);
    run_cmd(v, r);
    check_cmd(v, r, "wrap");
    chk("wrap_zero", commitCount, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
